// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream of the reader.
// The master modport is the reader side; the slave modport is the FIFO plus the sink.
interface fifo_stream_reader_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a framed valid/ready stream,
// using a 2-entry output buffer and read credits so no word is lost under backpressure.
module fifo_stream_reader #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  fifo_stream_reader_if.master  bus,
  output logic                  busy_o,
  output logic [15:0]           pkt_cnt_o
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  state_e              st_q, st_d;
  logic [1:0]          occ_q, occ_d;
  logic                inflight_q;
  logic [DATA_W-1:0]   head_q, tail_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [15:0]         pkt_cnt_q;

  logic                valid;
  logic                pop;
  logic                push;
  logic                rd_en;
  logic [2:0]          credit;

  assign valid  = (occ_q != 2'd0);
  assign pop    = valid & bus.m_ready;
  assign push   = inflight_q;
  // Words already owned (buffered or in flight) minus the one leaving this cycle.
  assign credit = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

  always_ff @(posedge clk) begin
    if (!rst) st_q <= IDLE;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (en_i) st_d = RUN;
      RUN:  if (!en_i) st_d = STOP;
      STOP: begin
        if (en_i)                                   st_d = RUN;
        else if (occ_q == 2'd0 && !inflight_q)      st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // Gating on en_i as well as RUN stops reads in the very cycle enable drops.
  always_comb begin
    rd_en  = rst & (st_q == RUN) & en_i & !bus.fifo_empty & (credit < 3'd2);
    busy_o = (st_q != IDLE);
  end

  assign occ_d = occ_q + 2'(push) - 2'(pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      pkt_cnt_q  <= 16'd0;
    end else begin
      inflight_q <= rd_en;
      occ_q      <= occ_d;
      // Capture is unconditional: the credit check guarantees a free slot.
      if (push && pop) begin
        if (occ_q == 2'd2) begin
          head_q <= tail_q;
          tail_q <= bus.fifo_dout;
        end else begin
          head_q <= bus.fifo_dout;
        end
      end else if (push) begin
        if (occ_q == 2'd0) head_q <= bus.fifo_dout;
        else               tail_q <= bus.fifo_dout;
      end else if (pop) begin
        head_q <= tail_q;
      end
      if (pop) begin
        if (beat_q == BEAT_LAST) begin
          beat_q    <= '0;
          pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end else begin
          beat_q <= beat_q + BEAT_W'(1);
        end
      end
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = head_q;
  assign bus.m_last     = valid & (beat_q == BEAT_LAST);
  assign pkt_cnt_o      = pkt_cnt_q;

endmodule
